// File: rtl/pio_pin_arbiter_if.sv
// Bundle between the state-machine execution units and the PIO pad arbiter.
// Flat per-SM vectors: SM i owns slice [W*i +: W] of each field.
interface pio_pin_arbiter_if #(
  parameter int unsigned NUM_SM = 4
);
  logic [NUM_SM-1:0]    out_valid;
  logic [32*NUM_SM-1:0] out_data;
  logic [5*NUM_SM-1:0]  out_base;
  logic [6*NUM_SM-1:0]  out_count;
  logic [NUM_SM-1:0]    dir_valid;
  logic [32*NUM_SM-1:0] dir_data;
  logic [5*NUM_SM-1:0]  dir_base;
  logic [6*NUM_SM-1:0]  dir_count;
  logic [NUM_SM-1:0]    side_valid;
  logic [NUM_SM-1:0]    side_pindir;
  logic [5*NUM_SM-1:0]  side_data;
  logic [5*NUM_SM-1:0]  side_base;
  logic [3*NUM_SM-1:0]  side_count;
  logic [5*NUM_SM-1:0]  in_base;
  logic [31:0]          pad_in;
  logic [31:0]          pad_out;
  logic [31:0]          pad_oe;
  logic [32*NUM_SM-1:0] in_data;
  logic                 conflict;

  // SM / pad side: drives writes and raw pads, observes pad state
  modport master (
    output out_valid, out_data, out_base, out_count,
    output dir_valid, dir_data, dir_base, dir_count,
    output side_valid, side_pindir, side_data, side_base, side_count,
    output in_base, pad_in,
    input  pad_out, pad_oe, in_data, conflict
  );

  // Arbiter side
  modport slave (
    input  out_valid, out_data, out_base, out_count,
    input  dir_valid, dir_data, dir_base, dir_count,
    input  side_valid, side_pindir, side_data, side_base, side_count,
    input  in_base, pad_in,
    output pad_out, pad_oe, in_data, conflict
  );
endinterface

// File: rtl/pio_pin_arbiter.sv
// PIO pad bank arbiter: merges per-SM value/direction/side-set writes into
// registered pad value and output-enable registers (later SM and side-set win),
// flags same-pin multi-SM writes, and returns a synchronised, per-SM rotated IN view.
module pio_pin_arbiter #(
  parameter int unsigned NUM_SM   = 4,
  parameter int unsigned NUM_PINS = 32,
  parameter int unsigned SYNC_STG = 2
) (
  input logic              clock,
  input logic              reset_n,
  pio_pin_arbiter_if.slave bus
);

  logic [NUM_PINS-1:0]              pad_out_q, pad_out_d;
  logic [NUM_PINS-1:0]              pad_oe_q, pad_oe_d;
  logic                             conflict_q, conflict_d;
  logic [SYNC_STG-1:0][NUM_PINS-1:0] sync_q;

  // Per-iteration temporaries of the merge loop
  logic [31:0] out_m, out_v, dir_m, dir_v, side_m, side_v;
  logic [31:0] side_to_val, side_to_dir, sm_val_m, sm_dir_m;
  logic [31:0] seen_val, seen_dir;

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] t;
    t = {x, x} << s;
    return t[63:32];
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] t;
    t = {x, x} >> s;
    return t[31:0];
  endfunction

  // Unrotated window mask; counts above 32 behave as 32
  function automatic logic [31:0] win_mask(input logic [5:0] c);
    if (c >= 6'd32) return 32'hFFFF_FFFF;
    return (32'd1 << c[4:0]) - 32'd1;
  endfunction

  // Side-set mask; counts above 5 behave as 5
  function automatic logic [4:0] side_mask(input logic [2:0] c);
    if (c >= 3'd5) return 5'h1F;
    return (5'd1 << c) - 5'd1;
  endfunction

  // Merge all writers in ascending priority and detect cross-SM overlap per field
  always_comb begin
    pad_out_d   = pad_out_q;
    pad_oe_d    = pad_oe_q;
    conflict_d  = 1'b0;
    seen_val    = '0;
    seen_dir    = '0;
    out_m       = '0;
    out_v       = '0;
    dir_m       = '0;
    dir_v       = '0;
    side_m      = '0;
    side_v      = '0;
    side_to_val = '0;
    side_to_dir = '0;
    sm_val_m    = '0;
    sm_dir_m    = '0;
    for (int i = 0; i < NUM_SM; i++) begin
      out_m = bus.out_valid[i] ?
              rotl(win_mask(bus.out_count[6*i +: 6]), bus.out_base[5*i +: 5]) : '0;
      out_v = rotl(bus.out_data[32*i +: 32], bus.out_base[5*i +: 5]) & out_m;
      dir_m = bus.dir_valid[i] ?
              rotl(win_mask(bus.dir_count[6*i +: 6]), bus.dir_base[5*i +: 5]) : '0;
      dir_v = rotl(bus.dir_data[32*i +: 32], bus.dir_base[5*i +: 5]) & dir_m;
      side_m = bus.side_valid[i] ?
               rotl({27'd0, side_mask(bus.side_count[3*i +: 3])}, bus.side_base[5*i +: 5]) : '0;
      side_v = rotl({27'd0, bus.side_data[5*i +: 5]}, bus.side_base[5*i +: 5]) & side_m;
      side_to_val = bus.side_pindir[i] ? '0 : side_m;
      side_to_dir = bus.side_pindir[i] ? side_m : '0;

      // Side-set applied after out/dir of the same SM so it wins silently
      pad_out_d = (pad_out_d & ~out_m) | out_v;
      pad_out_d = (pad_out_d & ~side_to_val) | (side_v & side_to_val);
      pad_oe_d  = (pad_oe_d & ~dir_m) | dir_v;
      pad_oe_d  = (pad_oe_d & ~side_to_dir) | (side_v & side_to_dir);

      sm_val_m = out_m | side_to_val;
      sm_dir_m = dir_m | side_to_dir;
      if ((|(seen_val & sm_val_m)) || (|(seen_dir & sm_dir_m))) conflict_d = 1'b1;
      seen_val = seen_val | sm_val_m;
      seen_dir = seen_dir | sm_dir_m;
    end
  end

  // Pad value/enable registers and registered conflict pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pad_out_q  <= '0;
      pad_oe_q   <= '0;
      conflict_q <= 1'b0;
    end else begin
      pad_out_q  <= pad_out_d;
      pad_oe_q   <= pad_oe_d;
      conflict_q <= conflict_d;
    end
  end

  // Input synchroniser chain; stage SYNC_STG-1 is the settled value
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= bus.pad_in;
      for (int s = 1; s < SYNC_STG; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Per-SM IN view: settled pads rotated right so pin in_base lands on bit 0
  always_comb begin
    bus.in_data = '0;
    for (int i = 0; i < NUM_SM; i++) begin
      bus.in_data[32*i +: 32] = rotr(sync_q[SYNC_STG-1], bus.in_base[5*i +: 5]);
    end
  end

  assign bus.pad_out  = pad_out_q;
  assign bus.pad_oe   = pad_oe_q;
  assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_pio_pin_arbiter.sv
// Directed + random bench for pio_pin_arbiter against a per-pin reference model.
module tb_pio_pin_arbiter;
  localparam int unsigned NSM  = 4;
  localparam int unsigned SYNC = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  pio_pin_arbiter_if #(.NUM_SM(NSM)) bus ();

  pio_pin_arbiter #(.NUM_SM(NSM), .NUM_PINS(32), .SYNC_STG(SYNC)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Stimulus, one entry per SM
  logic        o_v [NSM];
  logic [31:0] o_d [NSM];
  logic [4:0]  o_b [NSM];
  logic [5:0]  o_c [NSM];
  logic        d_v [NSM];
  logic [31:0] d_d [NSM];
  logic [4:0]  d_b [NSM];
  logic [5:0]  d_c [NSM];
  logic        s_v [NSM];
  logic        s_pd[NSM];
  logic [4:0]  s_d [NSM];
  logic [4:0]  s_b [NSM];
  logic [2:0]  s_c [NSM];
  logic [4:0]  i_b [NSM];
  logic [31:0] pin;

  // Reference state
  logic [31:0] exp_out, exp_oe;
  logic        exp_conf;
  logic [31:0] hist[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NSM; i++) begin
      o_v[i] = 0; o_d[i] = 0; o_b[i] = 0; o_c[i] = 0;
      d_v[i] = 0; d_d[i] = 0; d_b[i] = 0; d_c[i] = 0;
      s_v[i] = 0; s_pd[i] = 0; s_d[i] = 0; s_b[i] = 0; s_c[i] = 0;
    end
  endtask

  task automatic rand_stim();
    for (int i = 0; i < NSM; i++) begin
      o_v[i] = 1'($urandom_range(0, 1)); o_d[i] = $urandom;
      o_b[i] = 5'($urandom); o_c[i] = 6'($urandom_range(0, 40));
      d_v[i] = 1'($urandom_range(0, 1)); d_d[i] = $urandom;
      d_b[i] = 5'($urandom); d_c[i] = 6'($urandom_range(0, 40));
      s_v[i] = 1'($urandom_range(0, 1)); s_pd[i] = 1'($urandom_range(0, 1));
      s_d[i] = 5'($urandom); s_b[i] = 5'($urandom); s_c[i] = 3'($urandom);
      i_b[i] = 5'($urandom);
    end
    pin = $urandom;
  endtask

  task automatic drive();
    for (int i = 0; i < NSM; i++) begin
      bus.out_valid[i]          = o_v[i];
      bus.out_data[32*i +: 32]  = o_d[i];
      bus.out_base[5*i +: 5]    = o_b[i];
      bus.out_count[6*i +: 6]   = o_c[i];
      bus.dir_valid[i]          = d_v[i];
      bus.dir_data[32*i +: 32]  = d_d[i];
      bus.dir_base[5*i +: 5]    = d_b[i];
      bus.dir_count[6*i +: 6]   = d_c[i];
      bus.side_valid[i]         = s_v[i];
      bus.side_pindir[i]        = s_pd[i];
      bus.side_data[5*i +: 5]   = s_d[i];
      bus.side_base[5*i +: 5]   = s_b[i];
      bus.side_count[3*i +: 3]  = s_c[i];
      bus.in_base[5*i +: 5]     = i_b[i];
    end
    bus.pad_in = pin;
  endtask

  // Per-pin model: walk writers in priority order, offset of pin within each window
  task automatic model_next(output logic [31:0] nv, output logic [31:0] no, output logic nc);
    int vw[32];
    int dw[32];
    int off, cnt;
    nv = exp_out; no = exp_oe; nc = 1'b0;
    for (int p = 0; p < 32; p++) begin vw[p] = -1; dw[p] = -1; end
    for (int i = 0; i < NSM; i++) begin
      for (int p = 0; p < 32; p++) begin
        if (o_v[i]) begin
          cnt = (int'(o_c[i]) > 32) ? 32 : int'(o_c[i]);
          off = (p - int'(o_b[i]) + 32) % 32;
          if (off < cnt) begin
            nv[p] = o_d[i][off];
            if (vw[p] >= 0 && vw[p] != i) nc = 1'b1;
            vw[p] = i;
          end
        end
        if (d_v[i]) begin
          cnt = (int'(d_c[i]) > 32) ? 32 : int'(d_c[i]);
          off = (p - int'(d_b[i]) + 32) % 32;
          if (off < cnt) begin
            no[p] = d_d[i][off];
            if (dw[p] >= 0 && dw[p] != i) nc = 1'b1;
            dw[p] = i;
          end
        end
        if (s_v[i]) begin
          cnt = (int'(s_c[i]) > 5) ? 5 : int'(s_c[i]);
          off = (p - int'(s_b[i]) + 32) % 32;
          if (off < cnt) begin
            if (s_pd[i]) begin
              no[p] = s_d[i][off];
              if (dw[p] >= 0 && dw[p] != i) nc = 1'b1;
              dw[p] = i;
            end else begin
              nv[p] = s_d[i][off];
              if (vw[p] >= 0 && vw[p] != i) nc = 1'b1;
              vw[p] = i;
            end
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] sync_e, e;
    chk({tag, "_pad_out"}, bus.pad_out, exp_out);
    chk({tag, "_pad_oe"}, bus.pad_oe, exp_oe);
    chk({tag, "_conflict"}, 32'(bus.conflict), 32'(exp_conf));
    sync_e = (hist.size() >= SYNC) ? hist[SYNC-1] : 32'd0;
    for (int i = 0; i < NSM; i++) begin
      for (int k = 0; k < 32; k++) e[k] = sync_e[(k + int'(i_b[i])) % 32];
      chk($sformatf("%s_in_data%0d", tag, i), bus.in_data[32*i +: 32], e);
    end
  endtask

  // One clocked cycle: apply stimulus, advance model, compare after the edge
  task automatic step(input string tag);
    logic [31:0] nv, no;
    logic nc;
    drive();
    model_next(nv, no, nc);
    @(posedge clock);
    #1;
    exp_out = nv; exp_oe = no; exp_conf = nc;
    hist.push_front(pin);
    if (hist.size() > SYNC) void'(hist.pop_back());
    check_all(tag);
  endtask

  task automatic model_reset();
    exp_out = 0; exp_oe = 0; exp_conf = 0;
    hist.delete();
  endtask

  initial begin
    // Reset held with all strobes active: outputs stay cleared
    for (int i = 0; i < NSM; i++) i_b[i] = 0;
    pin = 0;
    clear_stim();
    for (int i = 0; i < NSM; i++) begin
      o_v[i] = 1; o_d[i] = 32'hFFFF_FFFF; o_c[i] = 32;
      d_v[i] = 1; d_d[i] = 32'hFFFF_FFFF; d_c[i] = 32;
    end
    pin = 32'hFFFF_FFFF;
    drive();
    repeat (3) begin
      @(posedge clock);
      #1;
      chk("rst_pad_out", bus.pad_out, 32'd0);
      chk("rst_pad_oe", bus.pad_oe, 32'd0);
      chk("rst_conflict", 32'(bus.conflict), 32'd0);
      chk("rst_in_data0", bus.in_data[31:0], 32'd0);
    end
    clear_stim();
    pin = 0;
    drive();
    reset_n = 1'b1;
    model_reset();

    // Single out window
    o_v[0] = 1; o_d[0] = 32'hA5; o_b[0] = 4; o_c[0] = 8;
    step("t2");
    chk("t2_value", bus.pad_out, 32'h0000_0A50);

    // Direction window wrapping 31 -> 0
    clear_stim();
    d_v[1] = 1; d_d[1] = 32'hF; d_b[1] = 30; d_c[1] = 4;
    step("t3");
    chk("t3_oe", bus.pad_oe, 32'hC000_0003);
    chk("t3_out_held", bus.pad_out, 32'h0000_0A50);

    // Cross-SM priority with overlap
    clear_stim();
    o_v[0] = 1; o_d[0] = 32'hFF; o_b[0] = 0; o_c[0] = 8;
    o_v[3] = 1; o_d[3] = 32'h00; o_b[3] = 4; o_c[3] = 8;
    step("t4");
    chk("t4_value", bus.pad_out, 32'h0000_000F);
    chk("t4_conflict", 32'(bus.conflict), 32'd1);
    clear_stim();
    step("t4_idle");
    chk("t4_conflict_pulse", 32'(bus.conflict), 32'd0);

    // Same-SM out + side-set overlap: side wins, no conflict
    clear_stim();
    o_v[2] = 1; o_d[2] = 32'h0; o_b[2] = 0; o_c[2] = 4;
    s_v[2] = 1; s_pd[2] = 0; s_d[2] = 5'b00011; s_b[2] = 1; s_c[2] = 2;
    step("t5");
    chk("t5_value", bus.pad_out, 32'h0000_0006);
    chk("t5_conflict", 32'(bus.conflict), 32'd0);

    // count==0 from two SMs: no write, no conflict
    clear_stim();
    o_v[0] = 1; o_d[0] = 32'hFFFF_FFFF; o_c[0] = 0;
    o_v[1] = 1; o_d[1] = 32'hFFFF_FFFF; o_c[1] = 0;
    step("t6_cnt0");
    chk("t6_cnt0_value", bus.pad_out, 32'h0000_0006);
    chk("t6_cnt0_conflict", 32'(bus.conflict), 32'd0);

    // count==40 clamps to a full 32-pin window
    clear_stim();
    o_v[0] = 1; o_d[0] = 32'h1234_5678; o_b[0] = 8; o_c[0] = 40;
    step("t6_cnt40");
    chk("t6_cnt40_value", bus.pad_out, 32'h3456_7812);

    // Input sync latency: pin 5 seen on bit 0 of SM1 after SYNC edges
    clear_stim();
    i_b[1] = 5;
    pin = 0;
    repeat (SYNC + 1) step("t6_settle");
    pin = 32'h0000_0020;
    step("t6_edge1");
    chk("t6_in_early", 32'(bus.in_data[32]), 32'd0);
    step("t6_edge2");
    chk("t6_in_late", 32'(bus.in_data[32]), 32'd1);

    // Random traffic with one mid-operation reset
    for (int n = 0; n < 300; n++) begin
      rand_stim();
      if (n == 150) begin
        drive();
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_pad_out", bus.pad_out, 32'd0);
        chk("mid_rst_pad_oe", bus.pad_oe, 32'd0);
        chk("mid_rst_conflict", 32'(bus.conflict), 32'd0);
        chk("mid_rst_in_data", bus.in_data[31:0], 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
      end
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
